pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline boundary register; the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle through DEPTH back-to-back register slices.
- Per-slice valid bit; global stall (hold) and flush (bubble insert).
- Sits between any two core stages; the hazard unit drives stall/flush.

Parameters:
CTRL_W, 8, width of control bundle (mem_read, mem_write, memToReg, branch, reg_write, ...); cleared on flush.
DATA_W, 256, width of data bundle (pc, pc+imm, alu result, rd2, rd, zero, prediction, ...); never cleared by flush.
DEPTH, 1, number of register slices, legal 1..4; elaboration error outside range.
CNT_W, 32, width of perf counters (only used under the optional feature).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream stage holds a real instruction
in_ctrl  in  CTRL_W  control bundle from upstream
in_data  in  DATA_W  data bundle from upstream
stall  in  1  hold all slices this cycle
flush  in  1  convert all slices to bubbles this cycle
out_valid  out  1  last slice holds a real instruction
out_ctrl  out  CTRL_W  last-slice control, forced 0 when out_valid=0
out_data  out  DATA_W  last-slice data, passed regardless of valid
busy  out  1  OR of all slice valid bits
stall_cycles  out  CNT_W  perf: cycles with stall=1 and flush=0 (PIPE_REG_PERF_EN only)
flush_events  out  CNT_W  perf: cycles with flush=1 (PIPE_REG_PERF_EN only)

Behaviour:
- Reset (rst_n=0, async): every slice valid=0, ctrl=0, data=0. Outputs read 0 immediately, no clock needed. Counters reset to 0.
- Latency: DEPTH cycles from input to out_* when there is no stall or flush. Throughput is 1 per cycle.
- Priority per rising edge: flush > stall > advance.
- flush=1:
  - All slices get valid=0 and ctrl=0.
  - Data registers still load/shift as on advance. This keeps the legacy behaviour that data is never gated.
  - A simultaneous stall is ignored.
- stall=1, flush=0: every slice (valid, ctrl, data) holds its value. in_* is ignored; upstream must hold it.
- Advance:
  - slice[0] <= {in_valid, in_valid ? in_ctrl : 0, in_data}.
  - slice[i] <= slice[i-1] for i>0.
- in_valid=0 with nonzero in_ctrl: the stored ctrl is 0. A bubble can never assert mem_write or reg_write downstream.
- out_ctrl is combinationally ANDed with out_valid. This is redundant with the stored gating but is a required safety net.
- busy is combinational from the slice valid bits.
- Reset deasserting mid-stream: the first edge after release behaves as a normal advance. No partial state survives.
- DEPTH=1 must be cycle-equivalent to the existing single-stage register when stall=0 and in_valid=1.

Optional Feature:
Macro PIPE_REG_PERF_EN.
- Defined:
  - stall_cycles increments on each edge with stall=1 and flush=0.
  - flush_events increments on each edge with flush=1.
  - Both saturate at all-ones and do not wrap.
- Not defined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipeline_pkg: CTRL_W/DATA_W defaults per boundary (IF_ID, ID_EX, EX_MEM, MEM_WB), control-bit index constants, and the DEPTH legal-range constants.
- One natural sub-module, pipe_slice: a single valid+ctrl+data register with async reset, hold, bubble and load.
- pipe_stage_reg instantiates DEPTH pipe_slice in a generate loop, plus the output gating and the counters.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=1, in_ctrl=8'hFF, data=A5.. for 3 clocks -> out_valid=0, out_ctrl=0, out_data=0, busy=0; drop rst_n mid-cycle -> outputs 0 before the next edge.
2. Latency, DEPTH=3: inject valid tokens with data 1,2,3,4 on consecutive cycles -> out_data=1 at cycle 3 and then 2,3,4 on successive cycles, all with out_valid=1.
3. Stall: DEPTH=2, data 10,11 in flight; stall=1 for 4 cycles while in_data=99 -> outputs frozen at 10; after release the sequence is 10, 11, 99.
4. Flush+stall: in_ctrl=8'h1F valid in flight; assert flush=1 and stall=1 together -> next edge out_valid=0, out_ctrl=0, out_data has advanced; busy=0 after DEPTH flushed cycles.
5. Bubble gating: in_valid=0, in_ctrl=8'hFF -> after DEPTH cycles out_ctrl=0, out_valid=0.
6. PIPE_REG_PERF_EN, CNT_W=4: 20 stall cycles -> stall_cycles=15 (saturated); 3 flush cycles -> flush_events=3. With the macro undefined -> both read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the inter-stage pipeline registers: bundle widths per
// boundary, control-bit positions and the legal slice-depth range.
package pipeline_pkg;

  localparam int unsigned DepthMin = 1;
  localparam int unsigned DepthMax = 4;

  localparam int unsigned CtrlWDefault = 8;
  localparam int unsigned DataWDefault = 256;

  // Bundle widths per classic boundary
  localparam int unsigned IfIdCtrlW  = 1;
  localparam int unsigned IfIdDataW  = 97;
  localparam int unsigned IdExCtrlW  = 8;
  localparam int unsigned IdExDataW  = 168;
  localparam int unsigned ExMemCtrlW = 5;
  localparam int unsigned ExMemDataW = 134;
  localparam int unsigned MemWbCtrlW = 2;
  localparam int unsigned MemWbDataW = 69;

  // Control-bundle bit positions
  localparam int unsigned CtrlMemRead  = 0;
  localparam int unsigned CtrlMemWrite = 1;
  localparam int unsigned CtrlMemToReg = 2;
  localparam int unsigned CtrlBranch   = 3;
  localparam int unsigned CtrlRegWrite = 4;

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= DepthMin) && (depth <= DepthMax);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One pipeline register slice: valid + control + data with hold (stall) and
// bubble insertion (flush). Control is stored only for valid entries.
module pipe_slice #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      // Data keeps moving on a flush; only valid and control are killed
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = in_data;
    end else if (!stall) begin
      valid_d = in_valid;
      ctrl_d  = in_valid ? in_ctrl : '0;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH chained pipe_slice instances.
// Optional saturating perf counters under macro PIPE_REG_PERF_EN.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlWDefault,
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  if (!depth_legal(DEPTH)) begin : gen_depth_check
    $error("pipe_stage_reg: DEPTH=%0d outside legal range %0d..%0d", DEPTH, DepthMin, DepthMax);
  end

  // Index 0 is the upstream input; index i+1 is the output of slice i
  logic [DEPTH:0]    stage_valid;
  logic [CTRL_W-1:0] stage_ctrl [DEPTH+1];
  logic [DATA_W-1:0] stage_data [DEPTH+1];

  assign stage_valid[0] = in_valid;
  assign stage_ctrl[0]  = in_ctrl;
  assign stage_data[0]  = in_data;

  for (genvar i = 0; i < DEPTH; i++) begin : gen_slice
    pipe_slice #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (stall),
      .flush    (flush),
      .in_valid (stage_valid[i]),
      .in_ctrl  (stage_ctrl[i]),
      .in_data  (stage_data[i]),
      .out_valid(stage_valid[i+1]),
      .out_ctrl (stage_ctrl[i+1]),
      .out_data (stage_data[i+1])
    );
  end

  assign out_valid = stage_valid[DEPTH];
  // Redundant with the gating inside each slice, kept as a safety net
  assign out_ctrl  = stage_ctrl[DEPTH] & {CTRL_W{stage_valid[DEPTH]}};
  assign out_data  = stage_data[DEPTH];
  assign busy      = |stage_valid[DEPTH:1];

`ifdef PIPE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !flush && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && !(&flush_cnt_q))           flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a DEPTH=3 and a DEPTH=2
// instance (CNT_W=4), each with its own stimulus, sharing clock and reset.
module tb_pipe_stage_reg;

`ifdef PIPE_REG_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic          a_valid, a_stall, a_flush;
  logic [CW-1:0] a_ctrl;
  logic [DW-1:0] a_data;
  logic          a_out_valid, a_busy;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [NW-1:0] a_stall_cycles, a_flush_events;

  logic          b_valid, b_stall, b_flush;
  logic [CW-1:0] b_ctrl;
  logic [DW-1:0] b_data;
  logic          b_out_valid, b_busy;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [NW-1:0] b_stall_cycles, b_flush_events;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CNT_W(NW)) u_d3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (a_valid),
    .in_ctrl     (a_ctrl),
    .in_data     (a_data),
    .stall       (a_stall),
    .flush       (a_flush),
    .out_valid   (a_out_valid),
    .out_ctrl    (a_out_ctrl),
    .out_data    (a_out_data),
    .busy        (a_busy),
    .stall_cycles(a_stall_cycles),
    .flush_events(a_flush_events)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CNT_W(NW)) u_d2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (b_valid),
    .in_ctrl     (b_ctrl),
    .in_data     (b_data),
    .stall       (b_stall),
    .flush       (b_flush),
    .out_valid   (b_out_valid),
    .out_ctrl    (b_out_ctrl),
    .out_data    (b_out_data),
    .busy        (b_busy),
    .stall_cycles(b_stall_cycles),
    .flush_events(b_flush_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d);
    check({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    check({tag, ".ctrl"},  32'(a_out_ctrl),  32'(c));
    check({tag, ".data"},  32'(a_out_data),  32'(d));
  endtask

  task automatic check_b(input string tag, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d);
    check({tag, ".valid"}, 32'(b_out_valid), 32'(v));
    check({tag, ".ctrl"},  32'(b_out_ctrl),  32'(c));
    check({tag, ".data"},  32'(b_out_data),  32'(d));
  endtask

  initial begin
    // 1. Reset holds everything at zero despite live inputs
    rst_n = 1'b0;
    a_valid = 1'b1; a_ctrl = 8'hFF; a_data = 16'hA5A5; a_stall = 1'b0; a_flush = 1'b0;
    b_valid = 1'b1; b_ctrl = 8'hFF; b_data = 16'hA5A5; b_stall = 1'b0; b_flush = 1'b0;
    tick(); tick(); tick();
    check_a("rst_a", 1'b0, 8'h00, 16'h0000);
    check("rst_a.busy", 32'(a_busy), 32'd0);
    check_b("rst_b", 1'b0, 8'h00, 16'h0000);
    check("rst_b.busy", 32'(b_busy), 32'd0);

    rst_n = 1'b1;
    b_valid = 1'b0; b_ctrl = 8'h00; b_data = 16'h0000;
    tick(); tick(); tick();
    check_a("fill_a", 1'b1, 8'hFF, 16'hA5A5);
    check("fill_a.busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_a("async_rst", 1'b0, 8'h00, 16'h0000);
    check("async_rst.busy", 32'(a_busy), 32'd0);
    a_valid = 1'b0; a_ctrl = 8'h00; a_data = 16'h0000;
    tick();
    rst_n = 1'b1;

    // 2. Latency and throughput on DEPTH=3
    a_valid = 1'b1;
    a_ctrl = 8'h11; a_data = 16'd1; tick();
    check("lat.not_yet", 32'(a_out_valid), 32'd0);
    a_ctrl = 8'h12; a_data = 16'd2; tick();
    check("lat.not_yet2", 32'(a_out_valid), 32'd0);
    a_ctrl = 8'h13; a_data = 16'd3; tick();
    check_a("lat1", 1'b1, 8'h11, 16'd1);
    a_ctrl = 8'h14; a_data = 16'd4; tick();
    check_a("lat2", 1'b1, 8'h12, 16'd2);
    a_valid = 1'b0; a_ctrl = 8'h00; a_data = 16'd0; tick();
    check_a("lat3", 1'b1, 8'h13, 16'd3);
    tick();
    check_a("lat4", 1'b1, 8'h14, 16'd4);
    tick();
    check("lat.drain", 32'(a_out_valid), 32'd0);

    // 3. Stall on DEPTH=2 freezes everything, in_* ignored
    b_valid = 1'b1; b_ctrl = 8'h0A;
    b_data = 16'd10; tick();
    b_data = 16'd11; tick();
    check_b("stl.pre", 1'b1, 8'h0A, 16'd10);
    b_stall = 1'b1; b_data = 16'd99;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_b($sformatf("stl.hold%0d", i), 1'b1, 8'h0A, 16'd10);
    end
    check("stl.count", 32'(b_stall_cycles), Perf ? 32'd4 : 32'd0);
    b_stall = 1'b0; tick();
    check_b("stl.rel1", 1'b1, 8'h0A, 16'd11);
    b_valid = 1'b0; b_data = 16'd0; tick();
    check_b("stl.rel2", 1'b1, 8'h0A, 16'd99);
    tick();
    check("stl.drain", 32'(b_out_valid), 32'd0);

    // 4. Flush wins over stall; data still shifts
    a_valid = 1'b1; a_ctrl = 8'h1F;
    a_data = 16'h50; tick();
    a_data = 16'h51; tick();
    a_data = 16'h52; tick();
    check_a("fl.pre", 1'b1, 8'h1F, 16'h50);
    a_flush = 1'b1; a_stall = 1'b1; a_data = 16'h53; tick();
    check_a("fl.e1", 1'b0, 8'h00, 16'h51);
    tick();
    check("fl.e2.data", 32'(a_out_data), 32'h52);
    tick();
    check_a("fl.e3", 1'b0, 8'h00, 16'h53);
    check("fl.busy", 32'(a_busy), 32'd0);
    check("fl.flush_cnt", 32'(a_flush_events), Perf ? 32'd3 : 32'd0);
    check("fl.stall_cnt", 32'(a_stall_cycles), 32'd0);
    a_flush = 1'b0; a_stall = 1'b0;

    // 5. Bubble with nonzero control never reaches the output as control
    a_valid = 1'b0; a_ctrl = 8'hFF; a_data = 16'h77;
    tick(); tick(); tick();
    check_a("bub", 1'b0, 8'h00, 16'h77);
    check("bub.busy", 32'(a_busy), 32'd0);

    // 6. Counters saturate at all-ones (CNT_W=4)
    b_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("perf.stall_sat", 32'(b_stall_cycles), Perf ? 32'd15 : 32'd0);
    b_flush = 1'b1;
    tick(); tick(); tick();
    b_flush = 1'b0; b_stall = 1'b0;
    check("perf.flush3", 32'(b_flush_events), Perf ? 32'd3 : 32'd0);
    check("perf.stall_held", 32'(b_stall_cycles), Perf ? 32'd15 : 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
